power_sequencer: RTL and testbench

- Multi-cycle controller that computes q = d**e with a runtime exponent, using square-and-multiply.
- One shared N*... M-bit multiplier handles every step, one multiply per cycle, instead of an unrolled chain of E-1 multipliers.
- Sits between an upstream producer and a downstream consumer, with valid/ready handshakes on both sides.
- Reports a sticky overflow flag when the true result does not fit in M bits.

---
 rtl/power_sequencer.sv | 166 ++++++++++++++++
 tb/tb_power_sequencer.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/power_sequencer.sv
// power_sequencer
//   Computes q = d**e (mod 2**M) with a runtime exponent using
//   square-and-multiply on a single shared M x M multiplier, one multiply
//   per clock. valid/ready handshakes on input and output; ovf is set when
//   the true result does not fit in M bits.
//
// Ports
//   clock      rising-edge clock
//   reset      asynchronous active-high reset
//   in_valid   d/e valid            in_ready   accepting (IDLE)
//   d [N-1:0]  base operand         e [EW-1:0] exponent
//   out_valid  q/ovf valid (DONE)   out_ready  downstream accepts result
//   q [M-1:0]  d**e mod 2**M        ovf        true result >= 2**M
//   busy       computing (CALC)
module power_sequencer #(
  parameter int unsigned N  = 4,
  parameter int unsigned EW = 4,
  parameter int unsigned M  = N * 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  d,
  input  logic [EW-1:0] e,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [M-1:0]  q,
  output logic          ovf,
  output logic          busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_e;

  typedef enum logic {
    PH_MUL,
    PH_SQR
  } phase_e;

  localparam logic [M-1:0] ONE = M'(1);

  state_e        state_q, state_d;
  phase_e        phase_q, phase_d;
  logic [M-1:0]  res_q,   res_d;
  logic [M-1:0]  base_q,  base_d;
  logic [EW-1:0] exp_q,   exp_d;
  logic          ovf_r_q, ovf_r_d;
  logic [M-1:0]  q_q,     q_d;
  logic          ovf_q,   ovf_d;

  // Shared multiplier datapath
  logic          do_res;
  logic [M-1:0]  mul_a;
  logic [M-1:0]  mul_b;
  logic [2*M-1:0] prod;
  logic          prod_hi_nz;
  logic [EW-1:0] exp_shr;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      phase_q <= PH_MUL;
      res_q   <= '0;
      base_q  <= '0;
      exp_q   <= '0;
      ovf_r_q <= 1'b0;
      q_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      res_q   <= res_d;
      base_q  <= base_d;
      exp_q   <= exp_d;
      ovf_r_q <= ovf_r_d;
      q_q     <= q_d;
      ovf_q   <= ovf_d;
    end
  end

  // The multiplier's "a" operand is res only for a real MUL step (exponent
  // bit set); otherwise the cycle is spent squaring base. A MUL phase with
  // a clear exponent bit therefore folds directly into a square.
  always_comb begin
    do_res     = (phase_q == PH_MUL) && exp_q[0];
    mul_a      = do_res ? res_q : base_q;
    mul_b      = base_q;
    prod       = {{M{1'b0}}, mul_a} * {{M{1'b0}}, mul_b};
    prod_hi_nz = |prod[2*M-1:M];
    exp_shr    = exp_q >> 1;
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    res_d   = res_q;
    base_d  = base_q;
    exp_d   = exp_q;
    ovf_r_d = ovf_r_q;
    q_d     = q_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          res_d   = ONE;
          base_d  = M'(d);
          exp_d   = e;
          ovf_r_d = 1'b0;
          if (e == '0) begin
            state_d = S_DONE;
            q_d     = ONE;
            ovf_d   = 1'b0;
          end else begin
            state_d = S_CALC;
            phase_d = PH_MUL;
          end
        end
      end

      S_CALC: begin
        ovf_r_d = ovf_r_q | prod_hi_nz;
        if (do_res) begin
          res_d = prod[M-1:0];
          // A remaining set bit above this one means base is still needed.
          // Base is never squared past the last use, so a flag raised on a
          // square always propagates into the true result.
          if (exp_shr != '0) begin
            phase_d = PH_SQR;
          end else begin
            state_d = S_DONE;
            q_d     = prod[M-1:0];
            ovf_d   = ovf_r_q | prod_hi_nz;
          end
        end else begin
          // exp is nonzero here and stays nonzero after the shift, because
          // a square is only entered when a higher set bit remains.
          base_d  = prod[M-1:0];
          exp_d   = exp_shr;
          phase_d = PH_MUL;
        end
      end

      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_CALC);
  assign q         = q_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_power_sequencer.sv
module tb_power_sequencer;

  localparam int unsigned N  = 4;
  localparam int unsigned EW = 4;
  localparam int unsigned M  = 8;

  logic          clock;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  d;
  logic [EW-1:0] e;
  logic          out_valid;
  logic          out_ready;
  logic [M-1:0]  q;
  logic          ovf;
  logic          busy;

  int checks = 0;
  int errors = 0;

  power_sequencer #(.N(N), .EW(EW), .M(M)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .d         (d),
    .e         (e),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .ovf       (ovf),
    .busy      (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Launch one operation and follow it to completion. Edge 1 is the
  // accepting edge; out_valid is expected after edge number exp_edges.
  task automatic run_op(input string tag, input logic [N-1:0] dv, input logic [EW-1:0] ev,
                        input logic early_rdy, input int hold,
                        input int exp_edges, input logic [M-1:0] exp_q, input logic exp_ovf);
    int edges;
    int busy_cnt;
    chk({tag, ".in_ready_pre"}, 32'(in_ready), 32'd1);
    d = dv;
    e = ev;
    in_valid = 1'b1;
    out_ready = early_rdy;
    @(posedge clock);
    edges = 1;
    #1;
    in_valid = 1'b0;
    d = ~dv;
    e = ~ev;
    busy_cnt = 0;
    while (!out_valid && edges < 40) begin
      if (busy) busy_cnt++;
      chk({tag, ".in_ready_busy"}, 32'(in_ready), 32'd0);
      @(posedge clock);
      edges++;
      #1;
    end
    chk({tag, ".latency"}, 32'(edges), 32'(exp_edges));
    chk({tag, ".busy_cycles"}, 32'(busy_cnt), 32'(exp_edges - 1));
    chk({tag, ".q"}, 32'(q), 32'(exp_q));
    chk({tag, ".ovf"}, 32'(ovf), 32'(exp_ovf));
    if (!early_rdy) begin
      for (int i = 0; i < hold; i++) begin
        @(posedge clock);
        #1;
        chk({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".hold_q"}, 32'(q), 32'(exp_q));
        chk({tag, ".hold_ovf"}, 32'(ovf), 32'(exp_ovf));
        chk({tag, ".hold_in_ready"}, 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
    end
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    chk({tag, ".idle_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, ".idle_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".idle_q_kept"}, 32'(q), 32'(exp_q));
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    d = '0;
    e = '0;
    #3;
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.q", 32'(q), 32'd0);
    chk("rst.ovf", 32'(ovf), 32'd0);
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // out_ready held high during CALC must be ignored
    run_op("d3e3",  4'd3,  4'd3,  1'b1, 0, 4, 8'd27,  1'b0);
    run_op("d15e2", 4'd15, 4'd2,  1'b0, 0, 3, 8'd225, 1'b0);
    run_op("d15e3", 4'd15, 4'd3,  1'b0, 0, 4, 8'd47,  1'b1);
    run_op("d9e0",  4'd9,  4'd0,  1'b0, 0, 1, 8'd1,   1'b0);
    run_op("d0e5",  4'd0,  4'd5,  1'b0, 0, 5, 8'd0,   1'b0);
    run_op("d2e15", 4'd2,  4'd15, 1'b0, 0, 8, 8'd0,   1'b1);
    run_op("d1e15", 4'd1,  4'd15, 1'b0, 0, 8, 8'd1,   1'b0);
    run_op("bp_d2e4", 4'd2, 4'd4, 1'b0, 5, 4, 8'd16,  1'b0);

    // Abort mid-CALC with an asynchronous reset
    d = 4'd3;
    e = 4'd7;
    in_valid = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1;
    chk("abort.busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("abort.in_ready", 32'(in_ready), 32'd1);
    chk("abort.out_valid", 32'(out_valid), 32'd0);
    chk("abort.busy", 32'(busy), 32'd0);
    chk("abort.q", 32'(q), 32'd0);
    chk("abort.ovf", 32'(ovf), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock);
      #1;
      chk("abort.no_result", 32'(out_valid), 32'd0);
    end
    run_op("after_rst_d3e2", 4'd3, 4'd2, 1'b0, 0, 3, 8'd9, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
